// File: rtl/minterm_fsm_eval.sv
// Reprogrammable sum-of-minterms evaluator: f = mask[in_vec], latency 1, stalls while out_valid && !out_ready or during a LOAD.
// Optional hit counter (port hit_cnt) is built only when SOP_EVAL_CNT_EN is defined.
module minterm_fsm_eval #(
    parameter int                      N_IN = 4,
    parameter logic [(1<<N_IN)-1:0]    MASK = 16'h0727
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_start,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_f
`ifdef SOP_EVAL_CNT_EN
    ,
    output logic [15:0]     hit_cnt
`endif
);
    localparam int MW = 1 << N_IN;
    localparam logic [N_IN:0] LAST = (N_IN+1)'(MW - 1);

    typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   mask_q, mask_d;
    logic [MW-1:0]   shadow_q, shadow_d;
    logic [N_IN:0]   cnt_q, cnt_d;
    logic            ov_q, ov_d;
    logic            of_q, of_d;
    logic            accept;
    logic            commit;

    assign in_ready  = (state_q == RUN) && (!ov_q || out_ready);
    assign cfg_busy  = (state_q == LOAD);
    assign out_valid = ov_q;
    assign out_f     = of_q;
    assign accept    = in_valid && in_ready;
    assign commit    = (state_q == LOAD) && (cnt_q == LAST);

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        ov_d     = ov_q;
        of_d     = of_q;

        // A pending result drains independently of RUN/LOAD.
        if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end
        if (accept) begin
            ov_d = 1'b1;
            of_d = mask_q[in_vec];
        end

        case (state_q)
            RUN: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                shadow_d[cnt_q[N_IN-1:0]] = cfg_bit;
                if (cnt_q == LAST) begin
                    // Commit includes the bit sampled this very cycle.
                    mask_d  = shadow_d;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            mask_q   <= MASK;
            shadow_q <= '0;
            cnt_q    <= '0;
            ov_q     <= 1'b0;
            of_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            ov_q     <= ov_d;
            of_q     <= of_d;
        end
    end

`ifdef SOP_EVAL_CNT_EN
    logic [15:0] hit_q, hit_d;

    always_comb begin
        hit_d = hit_q;
        if (commit) begin
            hit_d = '0;
        end else if (ov_q && out_ready && of_q && (hit_q != 16'hFFFF)) begin
            hit_d = hit_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_cnt = hit_q;
`else
    logic unused_commit;
    assign unused_commit = commit;
`endif

endmodule

// File: tb/tb_minterm_fsm_eval.sv
// Bench for minterm_fsm_eval: directed literal checks plus randomized traffic against a behavioural model.
module tb_minterm_fsm_eval;
    logic        clk = 1'b0;
    logic        rst_n, cfg_start, cfg_bit, in_valid, out_ready;
    logic [3:0]  in_vec;
    logic        cfg_busy, in_ready, out_valid, out_f;
`ifdef SOP_EVAL_CNT_EN
    logic [15:0] hit_cnt;
`endif

    minterm_fsm_eval #(.N_IN(4), .MASK(16'h0727)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_bit(cfg_bit),
        .cfg_busy(cfg_busy), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f)
`ifdef SOP_EVAL_CNT_EN
        , .hit_cnt(hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: truth table, a pending-result slot and a bit-serial loader.
    logic        model_live = 1'b0;
    logic [15:0] m_mask, m_shadow, m_hits;
    logic        m_busy, m_ov, m_of, m_rdy, m_fire;
    int          m_idx;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mask = 16'h0727; m_shadow = '0; m_busy = 1'b0; m_idx = 0;
            m_ov = 1'b0; m_of = 1'b0; m_hits = '0; model_live = 1'b1;
        end else if (model_live) begin
            m_rdy  = !m_busy && (!m_ov || out_ready);
            m_fire = m_ov && out_ready;
            if (m_fire && m_of && m_hits != 16'hFFFF) m_hits = m_hits + 16'd1;
            if (m_rdy && in_valid) begin
                m_ov = 1'b1;
                m_of = m_mask[in_vec];
            end else if (m_fire) begin
                m_ov = 1'b0;
            end
            if (m_busy) begin
                m_shadow[m_idx[3:0]] = cfg_bit;
                m_idx = m_idx + 1;
                if (m_idx == 16) begin
                    m_mask = m_shadow; m_busy = 1'b0; m_idx = 0; m_hits = '0;
                end
            end else if (cfg_start) begin
                m_busy = 1'b1;
                m_idx  = 0;
            end
        end
    end

    logic got_q[$];

    always @(negedge clk) begin
        if (model_live && rst_n) begin
            check("out_valid", out_valid, m_ov);
            if (m_ov) check("out_f", out_f, m_of);
            check("cfg_busy", cfg_busy, m_busy);
            check("in_ready", in_ready, !m_busy && (!m_ov || out_ready));
`ifdef SOP_EVAL_CNT_EN
            check("hit_cnt", hit_cnt, m_hits);
`endif
            if (out_valid && out_ready) got_q.push_back(out_f);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; cfg_start = 1'b0; cfg_bit = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic eval1(input logic [3:0] v, output logic f);
        int tmo;
        f = 1'bx;
        in_valid = 1'b1; in_vec = v; out_ready = 1'b1;
        tmo = 0;
        #1;
        while (!in_ready && tmo < 40) begin
            step(); tmo++;
            #1;
        end
        if (tmo >= 40) begin
            check("eval_timeout", 32'd1, 32'd0);
        end else begin
            step();
            in_valid = 1'b0;
            #1;
            check("eval_valid", out_valid, 1'b1);
            f = out_f;
        end
        step();
    endtask

    logic [0:15] exp2 = 16'b1110_0100_1110_0000;
    logic [15:0] lmask = 16'h8001;
    logic        f;
    int          busy_cnt;

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_bit = 1'b0;
        in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        do_reset();

        // 1: idle after reset
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_f", out_f, 1'b0);
        check("rst_cfg_busy", cfg_busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        step();

        // 2: stream all minterms on the default mask
        got_q.delete();
        out_ready = 1'b1;
        for (int v = 0; v < 16; v++) begin
            in_valid = 1'b1; in_vec = 4'(v);
            step();
        end
        in_valid = 1'b0;
        step(); step();
        check("stream_count", got_q.size(), 16);
        for (int i = 0; i < 16 && i < got_q.size(); i++)
            check($sformatf("stream_f%0d", i), got_q[i], exp2[i]);
`ifdef SOP_EVAL_CNT_EN
        check("hit_after_stream", hit_cnt, 16'd7);
`endif

        // 3: backpressure hold
        in_valid = 1'b1; in_vec = 4'd5; out_ready = 1'b0;
        step();
        in_vec = 4'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_out_f", out_f, 1'b1);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1'b1);
        step();
        #1;
        check("bp_drained", out_valid, 1'b0);
        step();

        // 4: load 0x8001
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cfg_bit = (i < 16) ? lmask[i] : 1'b0;
            #1;
            if (cfg_busy) busy_cnt++;
            step();
        end
        check("load_busy_cycles", busy_cnt, 16);
`ifdef SOP_EVAL_CNT_EN
        check("hit_after_commit", hit_cnt, 16'd0);
`endif
        eval1(4'd15, f); check("load_f15", f, 1'b1);
        eval1(4'd0,  f); check("load_f0",  f, 1'b1);
        eval1(4'd1,  f); check("load_f1",  f, 1'b0);

        // 5: cfg_start together with an accept uses the old mask
        do_reset();
        in_valid = 1'b1; in_vec = 4'd3; cfg_start = 1'b1; out_ready = 1'b0;
        #1;
        check("start_accept_ready", in_ready, 1'b1);
        step();
        cfg_start = 1'b0; in_valid = 1'b0; cfg_bit = lmask[0];
        #1;
        check("start_old_valid", out_valid, 1'b1);
        check("start_old_f", out_f, 1'b0);
        check("start_busy", cfg_busy, 1'b1);
        out_ready = 1'b1;
        step();
        for (int i = 1; i < 16; i++) begin
            cfg_bit = lmask[i];
            step();
        end
        step();
        eval1(4'd15, f); check("start_new_f15", f, 1'b1);

        // reset in the middle of a load restores the reset mask
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cfg_bit = lmask[i];
            step();
        end
        do_reset();
        eval1(4'd0,  f); check("abort_f0",  f, 1'b1);
        eval1(4'd15, f); check("abort_f15", f, 1'b0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_vec    = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 9) < 7);
            cfg_start = ($urandom_range(0, 39) == 0);
            cfg_bit   = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0; cfg_start = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
